// File: rtl/intpipe_p.sv
// intpipe_p: three-stage integer pipeline (issue/read, execute, writeback)
// with an internal register file, a {V,C,N,Z} flags register and full
// forwarding from EX and WB into the issue stage. A valid/ready handshake
// on both ends lets the downstream consumer freeze the whole pipeline.
module intpipe_p #(
    parameter int WIDTH = 16,
    parameter int REGS  = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [AW-1:0]    in_a,
    input  logic [AW-1:0]    in_b,
    input  logic [AW-1:0]    in_c,
    input  logic             host_we,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_data,
    output logic             res_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [AW-1:0]    res_dst,
    output logic [3:0]       res_flags
);

    // Opcode encoding; 11..15 fall through to NOP behaviour.
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    // Ops 1..9 produce a register result; CMP only touches the flags.
    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    // Ops 1..10 update the flags register when they retire.
    function automatic logic op_sets_flags(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_CMP);
    endfunction

    // Global advance: only a held result that the consumer refuses stalls us.
    logic adv;

    // EX stage registers: operands are already resolved at issue.
    logic             ex_valid;
    logic [3:0]       ex_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [AW-1:0]    ex_dst;
    logic             ex_wr;
    logic             ex_fl;

    // WB stage registers: the retiring result and its side effects.
    logic             wb_valid;
    logic [WIDTH-1:0] wb_data;
    logic [AW-1:0]    wb_dst;
    logic             wb_wr;
    logic             wb_fl;
    logic [3:0]       wb_flags;
    logic             wb_commit;

    // Architectural state.
    logic [WIDTH-1:0] rf [REGS];
    logic [3:0]       flags_q;

    // ALU results for the instruction sitting in EX.
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;

    // Issue-stage operands after forwarding.
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    assign adv       = !(wb_valid && !out_ready);
    assign in_ready  = adv;
    assign wb_commit = wb_valid && adv;

    // A write to R0 is demoted to a non-writing op so it can never forward.
    assign ex_wr = ex_valid && op_writes(ex_op) && (ex_dst != '0);
    assign ex_fl = ex_valid && op_sets_flags(ex_op);

    assign sum_ext  = {1'b0, ex_a} + {1'b0, ex_b};
    assign diff_ext = {1'b0, ex_a} - {1'b0, ex_b};

    // Execute: compute the result and the candidate flags for the EX op.
    always_comb begin
        logic carry;
        logic ovf;
        alu_res = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (ex_op)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                carry   = sum_ext[WIDTH];
                ovf     = (ex_a[WIDTH-1] == ex_b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != ex_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff_ext[WIDTH-1:0];
                carry   = diff_ext[WIDTH];
                ovf     = (ex_a[WIDTH-1] != ex_b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != ex_a[WIDTH-1]);
            end
            OP_AND: alu_res = ex_a & ex_b;
            OP_OR:  alu_res = ex_a | ex_b;
            OP_XOR: alu_res = ex_a ^ ex_b;
            OP_NOT: alu_res = ~ex_a;
            OP_SHL: begin
                alu_res = {ex_a[WIDTH-2:0], 1'b0};
                carry   = ex_a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, ex_a[WIDTH-1:1]};
                carry   = ex_a[0];
            end
            OP_MOV: alu_res = ex_a;
            default: alu_res = '0;
        endcase
        alu_flags = {ovf, carry, alu_res[WIDTH-1], (alu_res == '0)};
    end

    // Source A: EX result beats WB result beats the register file.
    always_comb begin
        opnd_a = (in_a == '0) ? '0 : rf[in_a];
        if (wb_valid && wb_wr && (wb_dst == in_a)) begin
            opnd_a = wb_data;
        end
        if (ex_wr && (ex_dst == in_a)) begin
            opnd_a = alu_res;
        end
    end

    // Source B: same priority chain as source A.
    always_comb begin
        opnd_b = (in_b == '0) ? '0 : rf[in_b];
        if (wb_valid && wb_wr && (wb_dst == in_b)) begin
            opnd_b = wb_data;
        end
        if (ex_wr && (ex_dst == in_b)) begin
            opnd_b = alu_res;
        end
    end

    // Issue into EX on every advancing edge; an empty input becomes a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid <= 1'b0;
            ex_op    <= OP_NOP;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_dst   <= '0;
        end else if (adv) begin
            ex_valid <= in_valid;
            if (in_valid) begin
                ex_op  <= in_op;
                ex_a   <= opnd_a;
                ex_b   <= opnd_b;
                ex_dst <= in_c;
            end
        end
    end

    // Move the EX result into WB on every advancing edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_dst   <= '0;
            wb_wr    <= 1'b0;
            wb_fl    <= 1'b0;
            wb_flags <= '0;
        end else if (adv) begin
            wb_valid <= ex_valid;
            wb_data  <= alu_res;
            wb_dst   <= ex_dst;
            wb_wr    <= ex_wr;
            wb_fl    <= ex_fl;
            wb_flags <= alu_flags;
        end
    end

    // Register file: retiring result plus host port; WB wins a same-address clash.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (wb_commit && wb_wr) begin
                rf[wb_dst] <= wb_data;
            end
            if (host_we && (host_addr != '0) &&
                !(wb_commit && wb_wr && (wb_dst == host_addr))) begin
                rf[host_addr] <= host_data;
            end
        end
    end

    // Flags register follows the retiring flag-setting instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else if (wb_commit && wb_fl) begin
            flags_q <= wb_flags;
        end
    end

    assign res_valid = wb_valid;
    assign res_data  = wb_data;
    assign res_dst   = wb_dst;
    assign res_flags = flags_q;

endmodule

// File: tb/tb_intpipe_p.sv
// tb_intpipe_p: directed bench for intpipe_p with an in-order instruction
// model (architectural registers + queue of in-flight instructions) checked
// every cycle, plus hand-computed literal expectations.
module tb_intpipe_p;

    localparam int WIDTH = 16;
    localparam int REGS  = 8;
    localparam int AW    = 3;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = '0;
    logic [AW-1:0]    in_a = '0;
    logic [AW-1:0]    in_b = '0;
    logic [AW-1:0]    in_c = '0;
    logic             host_we = 1'b0;
    logic [AW-1:0]    host_addr = '0;
    logic [WIDTH-1:0] host_data = '0;
    logic             res_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] res_data;
    logic [AW-1:0]    res_dst;
    logic [3:0]       res_flags;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc_count    = 0;
    bit last_accepted;

    typedef struct {
        logic [3:0]       op;
        logic [AW-1:0]    dst;
        logic [WIDTH-1:0] data;
        logic [3:0]       fl;
        bit               wr;
        bit               setfl;
        int               t0;
    } entry_t;

    entry_t           pipe_q[$];
    logic [WIDTH-1:0] m_reg [REGS];
    logic [3:0]       m_flags;
    int               m_t;

    always #5 clk = ~clk;

    intpipe_p #(.WIDTH(WIDTH), .REGS(REGS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .host_we(host_we), .host_addr(host_addr), .host_data(host_data),
        .res_valid(res_valid), .out_ready(out_ready),
        .res_data(res_data), .res_dst(res_dst), .res_flags(res_flags)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Plain-arithmetic reference for one instruction.
    function automatic void model_exec(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       output logic [WIDTH-1:0] r, output logic [3:0] f);
        int ua, ub, sa, sb, full, smax;
        bit c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        smax = (1 << (WIDTH - 1)) - 1;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            OP_ADD: begin
                full = ua + ub;
                r = WIDTH'(full);
                c = full[WIDTH];
                v = ((sa + sb) > smax) || ((sa + sb) < -smax - 1);
            end
            OP_SUB, OP_CMP: begin
                r = WIDTH'(ua - ub);
                c = ua < ub;
                v = ((sa - sb) > smax) || ((sa - sb) < -smax - 1);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOT: r = ~a;
            OP_SHL: begin r = {a[WIDTH-2:0], 1'b0}; c = a[WIDTH-1]; end
            OP_SHR: begin r = {1'b0, a[WIDTH-1:1]}; c = a[0]; end
            OP_MOV: r = a;
            default: r = '0;
        endcase
        f = {v, c, r[WIDTH-1], (r == '0)};
    endfunction

    // Value an issuing instruction must see: youngest in-flight writer, else the registers.
    function automatic logic [WIDTH-1:0] model_operand(input logic [AW-1:0] src);
        if (src == '0) return '0;
        for (int i = pipe_q.size() - 1; i >= 0; i--) begin
            if (pipe_q[i].wr && (pipe_q[i].dst == src)) return pipe_q[i].data;
        end
        return m_reg[src];
    endfunction

    // Model update at each clock edge; m_t counts advancing edges.
    always @(posedge clk or negedge rst) begin : model_proc
        bit wb_full, m_adv, collided;
        logic [WIDTH-1:0] a, b, r;
        logic [3:0] f;
        entry_t e, old;
        if (!rst) begin
            for (int i = 0; i < REGS; i++) m_reg[i] = '0;
            m_flags = '0;
            pipe_q.delete();
            m_t = 0;
        end else begin
            wb_full  = (pipe_q.size() > 0) && (m_t == pipe_q[0].t0 + 1);
            m_adv    = !(wb_full && !out_ready);
            collided = 1'b0;
            e = '{op: '0, dst: '0, data: '0, fl: '0, wr: 1'b0, setfl: 1'b0, t0: 0};
            if (m_adv && in_valid) begin
                a = model_operand(in_a);
                b = model_operand(in_b);
                model_exec(in_op, a, b, r, f);
                e.op    = in_op;
                e.dst   = in_c;
                e.data  = r;
                e.fl    = f;
                e.wr    = (in_op >= OP_ADD) && (in_op <= OP_MOV) && (in_c != '0);
                e.setfl = (in_op >= OP_ADD) && (in_op <= OP_CMP);
            end
            if (m_adv && wb_full) begin
                old = pipe_q.pop_front();
                if (old.wr) m_reg[old.dst] = old.data;
                if (old.setfl) m_flags = old.fl;
                collided = old.wr && (old.dst == host_addr);
            end
            if (host_we && (host_addr != '0) && !collided) m_reg[host_addr] = host_data;
            if (m_adv) begin
                m_t++;
                if (in_valid) begin
                    e.t0 = m_t;
                    pipe_q.push_back(e);
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin : compare_proc
        bit exp_v;
        if (rst) begin
            exp_v = (pipe_q.size() > 0) && (m_t == pipe_q[0].t0 + 1);
            checkOutput("res_valid", 32'(res_valid), 32'(exp_v));
            checkOutput("in_ready", 32'(in_ready), 32'(!(exp_v && !out_ready)));
            checkOutput("res_flags", 32'(res_flags), 32'(m_flags));
            if (exp_v) begin
                checkOutput("res_dst", 32'(res_dst), 32'(pipe_q[0].dst));
                if ((pipe_q[0].op >= OP_ADD) && (pipe_q[0].op <= OP_CMP))
                    checkOutput("res_data", 32'(res_data), 32'(pipe_q[0].data));
            end
        end
    end

    // One clock edge with the given inputs; ends just after the edge.
    task automatic applyStimulus(input bit v, input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic [AW-1:0] c, input bit ordy, input bit hwe, input logic [AW-1:0] haddr,
                                 input logic [WIDTH-1:0] hdata);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_c      = c;
        out_ready = ordy;
        host_we   = hwe;
        host_addr = haddr;
        host_data = hdata;
        #1;
        last_accepted = v && in_ready;
        @(posedge clk);
        #1;
        cyc_count++;
    endtask

    task automatic issue(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
        applyStimulus(1'b1, op, a, b, c, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, OP_NOP, '0, '0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic host(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
        applyStimulus(1'b0, OP_NOP, '0, '0, '0, 1'b1, 1'b1, addr, data);
    endtask

    // Issue with a periodic consumer stall, holding the instruction until taken.
    task automatic issueHeld(input logic [3:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
        int tries;
        tries = 0;
        do begin
            applyStimulus(1'b1, op, a, b, c, (cyc_count % 5) != 2, 1'b0, '0, '0);
            tries++;
        end while (!last_accepted && tries < 20);
        if (!last_accepted) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept_timeout: got no accept after %0d cycles, expected accept", tries);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : stimulus
        #2;
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_res_dst", 32'(res_dst), 32'd0);
        checkOutput("rst_res_flags", 32'(res_flags), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("release_in_ready", 32'(in_ready), 32'd1);

        // Host setup, then a dependent ADD chain.
        host(3'd1, 16'd2);
        host(3'd2, 16'd3);
        issue(OP_ADD, 3'd1, 3'd2, 3'd3);
        checkOutput("add1_not_yet_valid", 32'(res_valid), 32'd0);
        issue(OP_ADD, 3'd3, 3'd1, 3'd4);
        checkOutput("add1_valid", 32'(res_valid), 32'd1);
        checkOutput("add1_data", 32'(res_data), 32'd5);
        checkOutput("add1_dst", 32'(res_dst), 32'd3);
        checkOutput("add1_flags", 32'(res_flags), 32'd0);
        issue(OP_ADD, 3'd4, 3'd3, 3'd5);
        checkOutput("add2_data", 32'(res_data), 32'd7);
        checkOutput("chain_in_ready", 32'(in_ready), 32'd1);
        issue(OP_SUB, 3'd1, 3'd2, 3'd6);
        checkOutput("add3_data", 32'(res_data), 32'd12);
        issue(OP_CMP, 3'd2, 3'd2, 3'd0);
        checkOutput("sub_data", 32'(res_data), 32'hFFFF);
        checkOutput("sub_dst", 32'(res_dst), 32'd6);
        idle();
        checkOutput("flags_after_sub", 32'(res_flags), 32'b0110);
        idle();
        checkOutput("bubble_valid", 32'(res_valid), 32'd0);
        checkOutput("flags_after_cmp", 32'(res_flags), 32'b0001);
        issue(OP_MOV, 3'd6, 3'd0, 3'd7);
        idle();
        checkOutput("r6_kept", 32'(res_data), 32'hFFFF);

        // Consumer stall for three edges.
        issue(OP_ADD, 3'd1, 3'd2, 3'd3);
        issue(OP_ADD, 3'd1, 3'd1, 3'd4);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, OP_ADD, 3'd2, 3'd2, 3'd5, 1'b0, 1'b0, '0, '0);
            checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
            checkOutput("stall_data", 32'(res_data), 32'd5);
            checkOutput("stall_dst", 32'(res_dst), 32'd3);
        end
        issue(OP_ADD, 3'd2, 3'd2, 3'd5);
        checkOutput("resume_data", 32'(res_data), 32'd4);
        idle();
        checkOutput("resume_data2", 32'(res_data), 32'd6);
        idle();

        // R0 is never written nor forwarded.
        issue(OP_ADD, 3'd1, 3'd2, 3'd0);
        issue(OP_MOV, 3'd0, 3'd0, 3'd7);
        idle();
        checkOutput("mov_r0", 32'(res_data), 32'd0);
        idle();

        // WB write wins over a same-address host write.
        issue(OP_ADD, 3'd2, 3'd5, 3'd7);
        idle();
        checkOutput("add_r7", 32'(res_data), 32'd9);
        applyStimulus(1'b0, OP_NOP, '0, '0, '0, 1'b1, 1'b1, 3'd7, 16'h55AA);
        issue(OP_MOV, 3'd7, 3'd0, 3'd6);
        idle();
        checkOutput("collision_r7", 32'(res_data), 32'd9);

        // Host write is not seen by the instruction accepted on the same edge.
        applyStimulus(1'b1, OP_MOV, 3'd1, 3'd0, 3'd2, 1'b1, 1'b1, 3'd1, 16'h00F0);
        issue(OP_MOV, 3'd1, 3'd0, 3'd3);
        checkOutput("host_same_edge", 32'(res_data), 32'd2);
        idle();
        checkOutput("host_next_edge", 32'(res_data), 32'h00F0);
        idle();

        // Signed overflow on ADD.
        host(3'd4, 16'h7FFF);
        issue(OP_ADD, 3'd4, 3'd4, 3'd5);
        idle();
        checkOutput("ovf_data", 32'(res_data), 32'hFFFE);
        idle();
        checkOutput("ovf_flags", 32'(res_flags), 32'b1010);

        // Mixed ops under periodic stalls, checked by the model.
        issueHeld(OP_ADD, 3'd5, 3'd4, 3'd6);
        issueHeld(OP_AND, 3'd1, 3'd3, 3'd7);
        issueHeld(OP_OR,  3'd1, 3'd2, 3'd1);
        issueHeld(OP_XOR, 3'd3, 3'd3, 3'd2);
        issueHeld(OP_NOT, 3'd6, 3'd0, 3'd3);
        issueHeld(OP_SHL, 3'd3, 3'd0, 3'd3);
        issueHeld(OP_SHR, 3'd3, 3'd0, 3'd4);
        issueHeld(OP_SHL, 3'd5, 3'd0, 3'd5);
        issueHeld(OP_SHR, 3'd6, 3'd0, 3'd6);
        issueHeld(OP_SUB, 3'd2, 3'd5, 3'd1);
        issueHeld(OP_CMP, 3'd5, 3'd4, 3'd0);
        issueHeld(OP_NOP, 3'd1, 3'd1, 3'd1);
        issueHeld(4'd13,  3'd2, 3'd2, 3'd2);
        issueHeld(OP_ADD, 3'd1, 3'd6, 3'd7);
        issueHeld(OP_SUB, 3'd7, 3'd7, 3'd7);
        issueHeld(OP_MOV, 3'd4, 3'd0, 3'd1);
        idle();
        idle();
        idle();

        // Asynchronous reset mid-stream.
        issue(OP_ADD, 3'd1, 3'd2, 3'd3);
        issue(OP_ADD, 3'd3, 3'd3, 3'd4);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("async_res_valid", 32'(res_valid), 32'd0);
        checkOutput("async_res_data", 32'(res_data), 32'd0);
        checkOutput("async_res_dst", 32'(res_dst), 32'd0);
        checkOutput("async_res_flags", 32'(res_flags), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue(OP_MOV, 3'd1, 3'd0, 3'd1);
        issue(OP_ADD, 3'd2, 3'd3, 3'd2);
        checkOutput("post_rst_r1", 32'(res_data), 32'd0);
        idle();
        checkOutput("post_rst_r2r3", 32'(res_data), 32'd0);
        for (int r = 4; r < REGS; r++) begin
            issue(OP_MOV, AW'(r), 3'd0, AW'(r));
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/intpipe_p.md
# intpipe_p

Parametrised successor to the fixed 16-bit integer pipeline. Three stages: issue/read, execute, writeback. Contains an internal register file, a flags register and a full forwarding network. Back-to-back dependent instructions issue with no bubbles, and a valid/ready handshake on both ends supports stalls. It sits between the instruction sequencer (upstream) and the result/trace consumer (downstream).

## Interface
- WIDTH, 16: datapath and register width, ≥4.
- REGS, 8: register count, a power of two ≥2; AW = log2(REGS). R0 reads as zero.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  pipeline accepts an instruction this cycle.
- in_op  in  4  opcode.
- in_a, in_b, in_c  in  AW each  source A, source B, destination.
- host_we  in  1  host register write strobe.
- host_addr  in  AW  host write address.
- host_data  in  WIDTH  host write data.
- res_valid  out  1  WB stage holds a result.
- out_ready  in  1  consumer takes the result.
- res_data  out  WIDTH  WB result.
- res_dst  out  AW  WB destination.
- res_flags  out  4  flags register {V,C,N,Z}.

## Operation
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB (A−B), 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 SHL A by 1, 8 SHR A by 1 (logical), 9 MOV A.
  - 10 CMP: computes A−B, updates flags only, no register write.
  - 11–15: treated as NOP.
- A NOP still occupies a slot and produces res_valid, but writes neither a register nor the flags.
- Flags are updated by ops 1–10:
  - Z: result == 0.
  - N: result MSB.
  - C: ADD carry-out; SUB/CMP borrow (A<B unsigned); SHL/SHR the bit shifted out; 0 for logic ops.
  - V: signed overflow for ADD/SUB/CMP; 0 otherwise.
- Arithmetic is modulo 2^WIDTH.
- Writes to R0 are discarded, and R0 is never a forwarding source.
- Advance condition: adv = !(res_valid && !out_ready). The pipeline is frozen when adv=0; in_ready = adv.
- Operand selection at issue, per source, in priority order:
  1. EX-stage ALU result, when EX holds a register-writing op with matching dst ≠ 0.
  2. WB-stage result, when WB holds a register-writing op with matching dst ≠ 0.
  3. Register file.
- Register file write: WB result is written at the edge where WB holds a writing op and adv=1.
- Host writes occur at any edge with host_we=1.
- Same-address collision: the WB write wins and the host write is dropped. Different addresses: both are written.
- Host writes are not forwarded. They become visible to instructions accepted on or after the following edge.
- Flags register updates at the same edge as the WB register write. res_flags shows the register (pre-update) value.

## Timing
- Reset (async, rst=0):
  - All registers, flags and stage valids cleared.
  - res_valid=0, res_data=0, res_dst=0, res_flags=0.
  - in_ready=1 the first cycle after release.
  - An in-flight instruction is lost; no partial write occurs.
- Latency: an instruction accepted at edge N is in EX during N..N+1 and in WB (res_valid=1) from edge N+1. It retires at the first edge ≥N+2 with out_ready=1.
- Throughput: 1 instruction/cycle with out_ready held at 1; zero bubbles for RAW hazards at distance 1 or 2.
- Bubble: an edge with adv=1 and in_valid=0 inserts a bubble. EX/WB valids shift, and res_valid may drop.
- Stall: with adv=0, all stage registers, res_* and the register file write are held; forwarding sources are held too.
- out_ready is sampled only when res_valid=1 (when res_valid=0, adv=1 regardless).
- in_op/in_a/in_b/in_c are ignored unless in_valid && in_ready.

## Test plan
- Reset, host write R1=2 and R2=3, then ADD R3=R1+R2 accepted at edge N → res_valid from N+1, res_data=5, res_dst=3, res_flags=0 (pre-update value, flags register still 0 from reset).
- ADD R3=R1+R2, ADD R4=R3+R1, ADD R5=R4+R3 on consecutive edges with out_ready=1 → results 5, 7, 12 on consecutive cycles; in_ready never 0.
- SUB R6=R1−R2 → res_data=0xFFFF. Then CMP R2,R2 → flags become N=1,C=1,V=0,Z=0 after SUB retires, and Z=1,N=0,C=0 after CMP retires; R6 unchanged by CMP.
- Hold out_ready=0 for 3 cycles with res_valid=1 → in_ready=0 and res_data/res_dst stable for those 3 cycles. Release → stream resumes with no loss or duplication.
- ADD R0=R1+R2 followed by MOV R7=R0 → R7=0. Simultaneous host write R7=0x55AA with a WB write to R7 of 9 → R7=9.
- Drive rst=0 asynchronously mid-stream with res_valid=1 → outputs zero immediately; all registers read 0 afterwards.
